// File: rtl/droop_pkg.sv
// Shared definitions for the droop emulator and its companion compensator.
// Holds the datapath widths, the 13-bit output range and the saturation
// helpers that fold the 17-bit difference into the output word.
package droop_pkg;

    localparam int DIN_W  = 16;
    localparam int DOUT_W = 13;
    localparam int W_W    = 7;
    localparam int ACC_W  = 48;
    localparam int MULT_W = DIN_W + W_W;   // 23-bit product register
    localparam int DIFF_W = DIN_W + 1;     // 17-bit difference

    localparam int DOUT_MAX = 4095;
    localparam int DOUT_MIN = -4096;

    // True when a 17-bit difference cannot be represented in the output word.
    function automatic logic out_of_range_s13(input logic signed [DIFF_W-1:0] v);
        return (v > DIFF_W'(DOUT_MAX)) || (v < DIFF_W'(DOUT_MIN));
    endfunction

    // Clamp a signed 17-bit value into [DOUT_MIN, DOUT_MAX].
    function automatic logic signed [DOUT_W-1:0] sat_s17_to_s13(input logic signed [DIFF_W-1:0] v);
        if (v > DIFF_W'(DOUT_MAX)) begin
            return DOUT_W'(DOUT_MAX);
        end else if (v < DIFF_W'(DOUT_MIN)) begin
            return DOUT_W'(DOUT_MIN);
        end else begin
            return v[DOUT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/droop_emulator_edge_sync.sv
// edge_sync: two-flop synchroniser followed by a rising-edge detector.
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   trig      strobe from outside the clk domain
//   trig_edge one-cycle pulse, high while trig_a=1 and trig_b=0
// Holding trig high yields exactly one pulse; pulses shorter than a clock
// period may be missed.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    output logic trig_edge
);

    logic trig_a;
    logic trig_b;

    // The asynchronous reset on both stages keeps them as discrete flops;
    // they cannot be packed into a reset-less shift-register primitive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_a <= 1'b0;
            trig_b <= 1'b0;
        end else begin
            trig_a <= trig;
            trig_b <= trig_a;
        end
    end

    assign trig_edge = trig_a & ~trig_b;

endmodule

// File: rtl/droop_emulator.sv
// droop_emulator: models single-pole AC-coupling droop, the inverse of the
// anti-droop IIR compensator. On each synchronised trig edge:
//   y[n] = x[n-2] - (sum of x[k]*w through k=n-3) >>> SCALE, saturated to 13 bits.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   trig          sample strobe (asynchronous, rising edge detected)
//   din           signed 16-bit input sample
//   droopWeight   signed 7-bit droop coefficient w
//   accClr_en     synchronous clear of accumulator and pipeline
//   satClr        clears the sticky saturation flag
//   satDetect     sticky accumulator-overflow / output-saturation flag
//   dout          signed 13-bit droop-affected output (held between edges)
//   dout_valid    one-cycle pulse when dout carries a primed result
module droop_emulator
    import droop_pkg::*;
#(
    parameter int SCALE = 15   // legal 1..31
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     trig,
    input  logic signed [DIN_W-1:0]  din,
    input  logic signed [W_W-1:0]    droopWeight,
    input  logic                     accClr_en,
    input  logic                     satClr,
    output logic                     satDetect,
    output logic signed [DOUT_W-1:0] dout,
    output logic                     dout_valid
);

    localparam int SLICE_HI = SCALE + DIN_W - 1;   // top bit of the scaled slice

    logic                     trig_edge;
    logic signed [W_W-1:0]    w_a;
    logic signed [W_W-1:0]    w_b;
    logic signed [DIN_W-1:0]  din_del;
    logic signed [DIN_W-1:0]  din_del_b;
    logic signed [MULT_W-1:0] multreg;
    logic signed [ACC_W-1:0]  acc;
    logic [1:0]               prime;

    logic signed [MULT_W-1:0] mult_next;
    logic signed [DIN_W-1:0]  acc_slice;
    logic signed [DIFF_W-1:0] diff;
    logic [ACC_W-1:SLICE_HI]  acc_hi;
    logic                     acc_ovf;
    logic                     sat_evt;

    edge_sync u_edge_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .trig      (trig),
        .trig_edge (trig_edge)
    );

    // Coefficient is retimed through two stages so it lines up with the
    // synchronised strobe; it is not affected by accClr_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_a <= '0;
            w_b <= '0;
        end else begin
            w_a <= droopWeight;
            w_b <= w_a;
        end
    end

    // Both operands widened to the product width first so the multiply is
    // evaluated at full precision.
    assign mult_next = MULT_W'(din_del) * MULT_W'(w_b);

    // Difference uses the accumulator value from before this edge's update.
    assign acc_slice = acc[SLICE_HI:SCALE];
    assign diff      = DIFF_W'(din_del_b) - DIFF_W'(acc_slice);

    // Bits above the scaled slice must be pure sign extension; anything else
    // means the slice no longer represents the integral. Evaluated every
    // cycle, so a persisting overflow re-arms satDetect after a clear.
    assign acc_hi  = acc[ACC_W-1:SLICE_HI];
    assign acc_ovf = (|acc_hi) && !(&acc_hi);
    assign sat_evt = trig_edge && out_of_range_s13(diff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_del    <= '0;
            din_del_b  <= '0;
            multreg    <= '0;
            acc        <= '0;
            prime      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            satDetect  <= 1'b0;
        end else if (accClr_en) begin
            // Clear wins over a coincident edge; dout keeps its last value.
            din_del    <= '0;
            din_del_b  <= '0;
            multreg    <= '0;
            acc        <= '0;
            prime      <= '0;
            dout_valid <= 1'b0;
            satDetect  <= 1'b0;
        end else begin
            dout_valid <= trig_edge && (prime == 2'd2);
            if (trig_edge) begin
                din_del   <= din;
                din_del_b <= din_del;
                multreg   <= mult_next;
                acc       <= acc + ACC_W'(multreg);   // wraps, overflow is only flagged
                dout      <= sat_s17_to_s13(diff);
                if (prime != 2'd2) begin
                    prime <= prime + 2'd1;
                end
            end
            if (satClr) begin
                satDetect <= 1'b0;
            end else if (acc_ovf || sat_evt) begin
                satDetect <= 1'b1;
            end
        end
    end

endmodule
